// File: rtl/mem_line_dram_pkg.sv
// Shared types for the line-DRAM model: per-channel FSM states and reply codes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/mem_line_dram_if.sv
// Read/write request-reply bus of the line DRAM. The requester uses the master
// modport, the memory uses the slave modport.
interface mem_line_dram_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
);
  logic                    r_req_valid;
  logic                    r_req_ready;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic                    r_rep_valid;
  logic                    r_rep_ready;
  logic [DATA_WIDTH-1:0]   r_rep_data;
  logic [1:0]              r_rep_resp;

  logic                    w_req_valid;
  logic                    w_req_ready;
  logic [ADDR_WIDTH-1:0]   w_req_addr;
  logic [DATA_WIDTH-1:0]   w_req_data;
  logic [DATA_WIDTH/8-1:0] w_req_mask;
  logic                    w_rep_valid;
  logic                    w_rep_ready;
  logic [1:0]              w_rep_resp;

  modport master (
    output r_req_valid, r_req_addr, r_rep_ready,
           w_req_valid, w_req_addr, w_req_data, w_req_mask, w_rep_ready,
    input  r_req_ready, r_rep_valid, r_rep_data, r_rep_resp,
           w_req_ready, w_rep_valid, w_rep_resp
  );

  modport slave (
    input  r_req_valid, r_req_addr, r_rep_ready,
           w_req_valid, w_req_addr, w_req_data, w_req_mask, w_rep_ready,
    output r_req_ready, r_rep_valid, r_rep_data, r_rep_resp,
           w_req_ready, w_rep_valid, w_rep_resp
  );
endinterface

// File: rtl/mem_line_dram_chan_ctrl.sv
// One channel controller: IDLE -> BUSY -> RESP -> IDLE with a latency counter.
// access_o marks the clock edge on which the storage access happens.
module mem_chan_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid_i,
  output logic req_ready_o,
  output logic rep_valid_o,
  input  logic rep_ready_i,
  output logic accept_o,
  output logic access_o
);

  chan_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // State and counter registers; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and handshake strobes. Access is gated by reset so a
  // request caught by reset never reaches storage.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    rep_valid_o = 1'b0;
    accept_o    = 1'b0;
    access_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = ~rst;
        if (req_valid_i && !rst) begin
          accept_o = 1'b1;
          if (LATENCY == 0) begin
            access_o = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          access_o = ~rst;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rep_valid_o = 1'b1;
        if (rep_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_line_dram.sv
// Line-organised DRAM model with independent read and write channels.
// Optional feature macro: MEM_LINE_DRAM_BOUNDS_CHECK_EN -- addresses at or above
// CAPACITY get SLVERR, zero read data and no write; otherwise addresses wrap.
module mem_line_dram
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 128,
  parameter int    CAPACITY   = 4096,
  parameter int    ADDR_WIDTH = 32,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input logic           clk,
  input logic           rst,
  mem_line_dram_if.slave bus
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFFSET = $clog2(NBYTES);
  localparam int DEPTH  = CAPACITY / NBYTES;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Line index from a byte address; offset bits dropped, upper bits wrap.
  function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a >> OFFSET) & ADDR_WIDTH'(DEPTH - 1));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic r_accept, r_access, w_accept, w_access;

  mem_chan_ctrl #(.LATENCY(LATENCY)) u_rd_ctrl (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(bus.r_req_valid),
    .req_ready_o(bus.r_req_ready),
    .rep_valid_o(bus.r_rep_valid),
    .rep_ready_i(bus.r_rep_ready),
    .accept_o   (r_accept),
    .access_o   (r_access)
  );

  mem_chan_ctrl #(.LATENCY(LATENCY)) u_wr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(bus.w_req_valid),
    .req_ready_o(bus.w_req_ready),
    .rep_valid_o(bus.w_rep_valid),
    .rep_ready_i(bus.w_rep_ready),
    .accept_o   (w_accept),
    .access_o   (w_access)
  );

  logic [ADDR_WIDTH-1:0] r_addr_q, w_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NBYTES-1:0]     w_mask_q;

  // Capture request payload on handshake.
  always_ff @(posedge clk) begin
    if (r_accept) r_addr_q <= bus.r_req_addr;
    if (w_accept) begin
      w_addr_q <= bus.w_req_addr;
      w_data_q <= bus.w_req_data;
      w_mask_q <= bus.w_req_mask;
    end
  end

  // With zero latency the access happens on the handshake edge, so use the
  // live request payload instead of the captured copy.
  logic [ADDR_WIDTH-1:0] r_acc_addr, w_acc_addr;
  logic [DATA_WIDTH-1:0] w_acc_data;
  logic [NBYTES-1:0]     w_acc_mask;
  assign r_acc_addr = (LATENCY == 0) ? bus.r_req_addr : r_addr_q;
  assign w_acc_addr = (LATENCY == 0) ? bus.w_req_addr : w_addr_q;
  assign w_acc_data = (LATENCY == 0) ? bus.w_req_data : w_data_q;
  assign w_acc_mask = (LATENCY == 0) ? bus.w_req_mask : w_mask_q;

  logic r_oob, w_oob;
`ifdef MEM_LINE_DRAM_BOUNDS_CHECK_EN
  assign r_oob = (64'(r_acc_addr) >= 64'(CAPACITY));
  assign w_oob = (64'(w_acc_addr) >= 64'(CAPACITY));
`else
  assign r_oob = 1'b0;
  assign w_oob = 1'b0;
`endif

  // Byte-masked line write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_access && !w_oob) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_acc_mask[i]) mem_q[line_idx(w_acc_addr)][8*i +: 8] <= w_acc_data[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q, w_resp_q;

  // Reply registers: loaded only on the access edge, so they hold through RESP.
  // A same-edge write is not visible here (pre-write data is read).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
      r_resp_q <= OKAY;
      w_resp_q <= OKAY;
    end else begin
      if (r_access) begin
        r_data_q <= r_oob ? '0 : mem_q[line_idx(r_acc_addr)];
        r_resp_q <= r_oob ? SLVERR : OKAY;
      end
      if (w_access) w_resp_q <= w_oob ? SLVERR : OKAY;
    end
  end

  assign bus.r_rep_data = r_data_q;
  assign bus.r_rep_resp = r_resp_q;
  assign bus.w_rep_resp = w_resp_q;

endmodule

// File: tb/tb_mem_line_dram.sv
// Directed bench for mem_line_dram: main DUT at LATENCY=2, second at LATENCY=3
// for the reset-during-BUSY case.
module tb_mem_line_dram;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  mem_line_dram_if #(.DATA_WIDTH(128), .ADDR_WIDTH(32)) b ();
  mem_line_dram_if #(.DATA_WIDTH(128), .ADDR_WIDTH(32)) b3 ();

  mem_line_dram #(.DATA_WIDTH(128), .CAPACITY(4096), .ADDR_WIDTH(32), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  mem_line_dram #(.DATA_WIDTH(128), .CAPACITY(4096), .ADDR_WIDTH(32), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(b3)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m,
                    output int lat);
    int n;
    b.w_req_addr = a; b.w_req_data = d; b.w_req_mask = m;
    b.w_rep_ready = 1'b1; b.w_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b.w_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("wr_hs_timeout", 128'(n), 128'd0);
    @(posedge clk); #1;
    b.w_req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.w_rep_valid && lat < 50);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [127:0] d, output logic [1:0] rs,
                    output int lat);
    int n;
    b.r_req_addr = a; b.r_rep_ready = 1'b1; b.r_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b.r_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("rd_hs_timeout", 128'(n), 128'd0);
    @(posedge clk); #1;
    b.r_req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.r_rep_valid && lat < 50);
    d = b.r_rep_data; rs = b.r_rep_resp;
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF_00000000DEADBEEF;
  localparam logic [127:0] D0 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [127:0] DA = 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555;
  localparam logic [127:0] DB = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;

  initial begin
    logic [127:0] d, d2;
    logic [1:0]   rs, rs2;
    int           lat, lat2, n, seen;

    b.r_req_valid = 0; b.r_req_addr = '0; b.r_rep_ready = 1;
    b.w_req_valid = 0; b.w_req_addr = '0; b.w_req_data = '0; b.w_req_mask = '0; b.w_rep_ready = 1;
    b3.r_req_valid = 0; b3.r_req_addr = '0; b3.r_rep_ready = 1;
    b3.w_req_valid = 0; b3.w_req_addr = '0; b3.w_req_data = '0; b3.w_req_mask = '0; b3.w_rep_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_ready", 128'(b.r_req_ready), 128'd0);
    chk("rst_w_ready", 128'(b.w_req_ready), 128'd0);
    chk("rst_r_valid", 128'(b.r_rep_valid), 128'd0);
    chk("rst_w_valid", 128'(b.w_rep_valid), 128'd0);
    chk("rst_r_data",  b.r_rep_data, 128'd0);
    chk("rst_r_resp",  128'(b.r_rep_resp), 128'd0);
    chk("rst_w_resp",  128'(b.w_rep_resp), 128'd0);
    chk("rst3_w_ready", 128'(b3.w_req_ready), 128'd0);
    @(posedge clk); #1;
    rst = 0; rst3 = 0;
    @(negedge clk);
    chk("post_rst_r_ready", 128'(b.r_req_ready), 128'd1);
    chk("post_rst_w_ready", 128'(b.w_req_ready), 128'd1);
    chk("post_rst3_w_ready", 128'(b3.w_req_ready), 128'd1);
    @(posedge clk); #1;

    // Basic write/read, latency T+3 at LATENCY=2
    wr(32'h40, D1, 16'hFFFF, lat);
    chk("wr_lat", 128'(lat), 128'd3);
    chk("wr_resp", 128'(b.w_rep_resp), 128'd0);
    rd(32'h40, d, rs, lat);
    chk("rd_lat", 128'(lat), 128'd3);
    chk("rd_data", d, D1);
    chk("rd_resp", 128'(rs), 128'd0);
    rd(32'h4F, d, rs, lat);
    chk("rd_offset_ignored", d, D1);

    // Byte masking
    wr(32'h100, 128'd0, 16'hFFFF, lat);
    wr(32'h100, {128{1'b1}}, 16'h000F, lat);
    rd(32'h100, d, rs, lat);
    chk("mask_low4", d, 128'h00000000_00000000_00000000_FFFFFFFF);
    wr(32'h100, 128'h11223344_55667788_99AABBCC_DDEEFF00, 16'h8001, lat);
    rd(32'h100, d, rs, lat);
    chk("mask_ends", d, 128'h11000000_00000000_00000000_FFFFFF00);
    wr(32'h40, {128{1'b1}}, 16'h0000, lat);
    chk("mask0_lat", 128'(lat), 128'd3);
    rd(32'h40, d, rs, lat);
    chk("mask0_unchanged", d, D1);

    // Read backpressure: 5 cycles with r_rep_ready low
    b.r_req_addr = 32'h40; b.r_rep_ready = 1'b0; b.r_req_valid = 1'b1;
    @(posedge clk); #1;
    b.r_req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 128'(b.r_rep_valid), 128'd1);
      chk("bp_data", b.r_rep_data, D1);
      chk("bp_req_ready", 128'(b.r_req_ready), 128'd0);
    end
    b.r_rep_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_released_valid", 128'(b.r_rep_valid), 128'd0);
    chk("bp_released_ready", 128'(b.r_req_ready), 128'd1);
    @(posedge clk); #1;

    // Same-cycle read and write to one line: read sees old data
    wr(32'h80, 128'h1, 16'hFFFF, lat);
    fork
      rd(32'h80, d, rs, lat);
      wr(32'h80, 128'h2, 16'hFFFF, lat2);
    join
    chk("rw_same_old", d, 128'h1);
    chk("rw_same_rlat", 128'(lat), 128'd3);
    chk("rw_same_wlat", 128'(lat2), 128'd3);
    rd(32'h80, d, rs, lat);
    chk("rw_same_new", d, 128'h2);

    // Address at CAPACITY
    wr(32'h0, D0, 16'hFFFF, lat);
    rd(32'h1000, d2, rs2, lat);
    chk("oob_lat", 128'(lat), 128'd3);
`ifdef MEM_LINE_DRAM_BOUNDS_CHECK_EN
    chk("oob_resp", 128'(rs2), 128'(SLVERR));
    chk("oob_data", d2, 128'd0);
`else
    chk("wrap_resp", 128'(rs2), 128'(OKAY));
    chk("wrap_data", d2, D0);
`endif

    // Reset during BUSY at LATENCY=3
    b3.w_req_addr = 32'h40; b3.w_req_data = DA; b3.w_req_mask = '1; b3.w_req_valid = 1'b1;
    @(posedge clk); #1;
    b3.w_req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    b3.w_req_data = DB; b3.w_req_valid = 1'b1;
    @(posedge clk); #1;
    b3.w_req_valid = 1'b0;
    rst3 = 1'b1;
    @(negedge clk);
    chk("rst_busy_w_ready", 128'(b3.w_req_ready), 128'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst_busy_ready_after", 128'(b3.w_req_ready), 128'd1);
    seen = int'(b3.w_rep_valid);
    repeat (8) begin @(negedge clk); if (b3.w_rep_valid) seen = 1; end
    chk("rst_busy_no_wrep", 128'(seen), 128'd0);
    @(posedge clk); #1;
    b3.r_req_addr = 32'h40; b3.r_req_valid = 1'b1;
    @(posedge clk); #1;
    b3.r_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b3.r_rep_valid && n < 20);
    chk("rst_busy_rd_lat", 128'(n), 128'd4);
    chk("rst_busy_line_kept", b3.r_rep_data, DA);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
